// File: rtl/sr04_multi_ranger.sv
// sr04_multi_ranger
// Multi-channel HC-SR04 ultrasonic ranging controller. The controller fires
// NUM_CH sensors one at a time in round-robin order. It measures each echo
// pulse in 1 us ticks and converts the width to centimetres (58 ticks per cm)
// without a divider. Each result is reported with a channel tag, a 1-cycle
// valid strobe and an error flag. The error flag covers two cases: no echo
// within TIMEOUT_US ticks, or an echo at or beyond MAX_CM.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   i_tick   1-cycle pulse every 1 us
//   start    1-cycle pulse, begins one sweep (ignored while busy)
//   i_auto   level, repeat sweeps continuously
//   i_echo   raw asynchronous echo inputs, one per channel
//   o_trig   trigger outputs, at most one high
//   o_dist   last reported distance in cm (0 on error)
//   o_ch     channel of last report
//   o_valid  1-cycle strobe when o_dist/o_ch/o_err update
//   o_err    last report was a timeout or an overrange
//   o_busy   controller is not idle
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start or i_auto
// TRIG      | trigger of current channel high for TRIG_US ticks
// WAIT_ECHO | waiting for echo rise, timeout after TIMEOUT_US ticks
// MEASURE   | echo high, counting ticks and centimetres
// REPORT    | one cycle, result registered and o_valid high
// GUARD     | GUARD_US quiet ticks before the next channel

module sr04_multi_ranger #(
  parameter int NUM_CH     = 4,
  parameter int TRIG_US    = 10,
  parameter int MAX_CM     = 400,
  parameter int TIMEOUT_US = 30000,
  parameter int GUARD_US   = 40000,
  parameter int DIST_W     = 9,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              start,
  input  logic              i_auto,
  input  logic [NUM_CH-1:0] i_echo,
  output logic [NUM_CH-1:0] o_trig,
  output logic [DIST_W-1:0] o_dist,
  output logic [CH_W-1:0]   o_ch,
  output logic              o_valid,
  output logic              o_err,
  output logic              o_busy
);

  localparam int CNT_MAX0 = (TIMEOUT_US > GUARD_US) ? TIMEOUT_US : GUARD_US;
  localparam int CNT_MAX  = (CNT_MAX0 > TRIG_US) ? CNT_MAX0 : TRIG_US;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int CM_W     = $clog2(MAX_CM + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    REPORT    = 3'd4,
    GUARD     = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [CH_W-1:0]   ch, ch_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [5:0]        sub, sub_nx;
  logic [CM_W-1:0]   cm, cm_nx;
  logic              rpt, rpt_err;
  logic [NUM_CH-1:0] echo_m, echo_s;
  logic              echo_cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= i_echo;
      echo_s <= echo_m;
    end
  end

  // Only the echo of the channel being ranged is ever looked at.
  assign echo_cur = echo_s[ch];

  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    cnt_nx   = cnt;
    sub_nx   = sub;
    cm_nx    = cm;
    rpt      = 1'b0;
    rpt_err  = 1'b0;
    case (state)
      IDLE: begin
        if (start || i_auto) begin
          state_nx = TRIG;
          ch_nx    = '0;
          cnt_nx   = '0;
        end
      end
      TRIG: begin
        if (i_tick) begin
          if (cnt == CNT_W'(TRIG_US - 1)) begin
            state_nx = WAIT_ECHO;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      WAIT_ECHO: begin
        // An echo that is already high on entry is taken as the echo.
        if (echo_cur) begin
          state_nx = MEASURE;
          cnt_nx   = '0;
          sub_nx   = '0;
          cm_nx    = '0;
        end else if (i_tick) begin
          if (cnt == CNT_W'(TIMEOUT_US - 1)) begin
            state_nx = REPORT;
            rpt      = 1'b1;
            rpt_err  = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      MEASURE: begin
        // The falling edge has priority over a coincident tick, so that
        // tick is not counted.
        if (!echo_cur) begin
          state_nx = REPORT;
          rpt      = 1'b1;
        end else if (i_tick) begin
          if (sub == 6'd57) begin
            sub_nx = '0;
            if (cm == CM_W'(MAX_CM - 1)) begin
              cm_nx    = CM_W'(MAX_CM);
              state_nx = REPORT;
              rpt      = 1'b1;
              rpt_err  = 1'b1;
            end else begin
              cm_nx = cm + 1'b1;
            end
          end else begin
            sub_nx = sub + 1'b1;
          end
        end
      end
      REPORT: begin
        state_nx = GUARD;
        cnt_nx   = '0;
      end
      GUARD: begin
        if (i_tick) begin
          if (cnt == CNT_W'(GUARD_US - 1)) begin
            cnt_nx = '0;
            if (ch != CH_W'(NUM_CH - 1)) begin
              ch_nx    = ch + 1'b1;
              state_nx = TRIG;
            end else if (i_auto) begin
              ch_nx    = '0;
              state_nx = TRIG;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ch      <= '0;
      cnt     <= '0;
      sub     <= '0;
      cm      <= '0;
      o_valid <= 1'b0;
      o_dist  <= '0;
      o_ch    <= '0;
      o_err   <= 1'b0;
    end else begin
      state   <= state_nx;
      ch      <= ch_nx;
      cnt     <= cnt_nx;
      sub     <= sub_nx;
      cm      <= cm_nx;
      // Results are loaded on entry to REPORT so they coincide with o_valid.
      o_valid <= rpt;
      if (rpt) begin
        o_ch   <= ch;
        o_err  <= rpt_err;
        o_dist <= rpt_err ? '0 : DIST_W'(cm);
      end
    end
  end

  // The trigger is decoded from state, so it drops as soon as reset asserts.
  assign o_trig = (state == TRIG) ? (NUM_CH'(1) << ch) : '0;
  assign o_busy = (state != IDLE);

endmodule
